moore_seq_driver: RTL

Stimulus transmitter for the five-state Moore sequence detector. It accepts target-state requests over a valid/ready handshake and keeps a shadow copy of the detector's state. Each cycle it emits the 2-bit symbol that moves the detector one step along the shortest path to the target, then reports arrival and the step count. It also checks the detector's 1-bit output against the shadow model's expected output.

---
 rtl/moore_seq_driver.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/moore_seq_driver.sv
// Drives a five-state Moore detector along shortest routes to requested states and shadows its state.
// Optional output checker is built when MOORE_DRV_CHECK_EN is defined.
module moore_seq_driver #(
    parameter int MAX_STEPS = 4,
    parameter bit PARK_EN   = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_target,
    output logic       req_ready,
    output logic [1:0] drv_sym,
    input  logic       fsm_out,
    output logic [2:0] shadow_state,
    output logic       done,
    output logic [2:0] done_steps,
    output logic       done_err,
    input  logic       err_clr,
    output logic       mismatch
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} ctl_e;

    localparam logic [2:0] MAX_L = 3'(MAX_STEPS);

    ctl_e       ctl_q, ctl_d;
    logic [2:0] shadow_q, shadow_d;
    logic [2:0] target_q, target_d;
    logic [2:0] steps_q, steps_d;
    logic       err_q, err_d;
    logic       at_target, timeout;

    function automatic logic [2:0] det_next(input logic [2:0] s, input logic [1:0] sym);
        logic [2:0] n;
        n = 3'd0;
        case (s)
            3'd0: case (sym)
                      2'b00:   n = 3'd0;
                      2'b01:   n = 3'd4;
                      2'b10:   n = 3'd1;
                      default: n = 3'd2;
                  endcase
            3'd1: n = (sym == 2'b00) ? 3'd0 : ((sym == 2'b10) ? 3'd2 : 3'd1);
            3'd2: n = sym[1] ? 3'd3 : 3'd1;
            3'd3: n = sym[0] ? 3'd4 : 3'd3;
            3'd4: n = (sym == 2'b11) ? 3'd4 : 3'd0;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] route_sym(input logic [2:0] s, input logic [2:0] t);
        logic [1:0] r;
        r = 2'b00;
        case (s)
            3'd0: case (t)
                      3'd0:         r = 2'b00;
                      3'd1:         r = 2'b10;
                      3'd2, 3'd3:   r = 2'b11;
                      default:      r = 2'b01;
                  endcase
            3'd1: r = (t == 3'd2 || t == 3'd3) ? 2'b10 : 2'b00;
            3'd2: r = (t == 3'd3 || t == 3'd4) ? 2'b10 : 2'b00;
            3'd3: r = (t == 3'd3) ? 2'b00 : 2'b01;
            3'd4: r = (t == 3'd4) ? 2'b11 : 2'b00;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // st2 has no self-loop, so its park symbol drifts the detector to st1
    function automatic logic [1:0] park_sym(input logic [2:0] s);
        logic [1:0] p;
        p = 2'b00;
        if (PARK_EN) begin
            if (s == 3'd1)      p = 2'b01;
            else if (s == 3'd4) p = 2'b11;
        end
        return p;
    endfunction

    assign at_target = (shadow_q == target_q);
    assign timeout   = (steps_q == MAX_L);

    always_ff @(posedge clock) begin
        if (reset) begin
            ctl_q    <= S_IDLE;
            shadow_q <= 3'd0;
            target_q <= 3'd0;
            steps_q  <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            ctl_q    <= ctl_d;
            shadow_q <= shadow_d;
            target_q <= target_d;
            steps_q  <= steps_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        ctl_d    = ctl_q;
        target_d = target_q;
        steps_d  = steps_q;
        err_d    = err_q;
        case (ctl_q)
            S_IDLE: if (req_valid) begin
                target_d = req_target;
                steps_d  = 3'd0;
                err_d    = (req_target > 3'd4);
                ctl_d    = (req_target > 3'd4) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (at_target) begin
                    ctl_d = S_DONE;
                end else if (timeout) begin
                    err_d = 1'b1;
                    ctl_d = S_DONE;
                end else begin
                    steps_d = steps_q + 3'd1;
                end
            end
            default: ctl_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (ctl_q == S_IDLE) && !reset;
        drv_sym    = park_sym(shadow_q);
        if (ctl_q == S_RUN && !at_target && !timeout)
            drv_sym = route_sym(shadow_q, target_q);
        done       = (ctl_q == S_DONE);
        done_steps = done ? steps_q : 3'd0;
        done_err   = done && err_q;
    end

    assign shadow_d     = det_next(shadow_q, drv_sym);
    assign shadow_state = shadow_q;

`ifdef MOORE_DRV_CHECK_EN
    logic rst_hold_q;
    logic mismatch_q, mismatch_d;

    function automatic logic exp_out(input logic [2:0] s);
        return (s == 3'd0) || (s == 3'd2) || (s == 3'd4);
    endfunction

    always_comb begin
        mismatch_d = mismatch_q;
        if (!rst_hold_q && (fsm_out != exp_out(shadow_q)))
            mismatch_d = 1'b1;
        else if (err_clr)
            mismatch_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rst_hold_q <= 1'b1;
            mismatch_q <= 1'b0;
        end else begin
            rst_hold_q <= 1'b0;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_chk;
    assign unused_chk = ^{fsm_out, err_clr};
    assign mismatch   = 1'b0;
`endif

endmodule
